// File: rtl/led_scroll_driver.sv
// Scrolling 4-digit message feeder for a 7-segment decoder: 16-entry message, 4-char window.
// Optional macro LED_SCROLL_BLANK_EN blanks the anodes on the first and last cycle of each slot.
module led_scroll_driver #(
  parameter int REFRESH_DIV = 16,
  parameter int SCROLL_DIV  = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] an,
  output logic [3:0] char,
  output logic [3:0] ptr
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLAST = SW'(SCROLL_DIV - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [3:0]    ptr_q, ptr_d;
  logic [3:0]    an_q, an_d;
  logic [3:0]    char_q, char_d;
  logic [3:0]    msg_q [16];
  logic          blank;

  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    slot_d = slot_q;
    if (rcnt_q == RLAST) begin
      rcnt_d = '0;
      slot_d = slot_q + 2'd1;
    end
    scnt_d = scnt_q;
    ptr_d  = ptr_q;
    if (enable) begin
      scnt_d = scnt_q + SW'(1);
      if (scnt_q == SLAST) begin
        scnt_d = '0;
        ptr_d  = ptr_q + 4'd1;
      end
    end
  end

  // Capture reads the pre-edge message, so a same-edge write is seen only from the next slot.
  always_comb begin
    char_d = char_q;
    if (rcnt_q == '0) char_d = msg_q[ptr_q + {2'b00, slot_q}];
`ifdef LED_SCROLL_BLANK_EN
    blank = (rcnt_q == '0) || (rcnt_q == RLAST);
`else
    blank = 1'b0;
`endif
    an_d = blank ? 4'b1111 : ~(4'b1000 >> slot_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt_q <= '0;
      slot_q <= '0;
      scnt_q <= '0;
      ptr_q  <= '0;
      an_q   <= 4'b1111;
      char_q <= 4'hD;
      for (int i = 0; i < 16; i++) msg_q[i] <= (i < 10) ? 4'(i) : 4'hD;
    end else begin
      rcnt_q <= rcnt_d;
      slot_q <= slot_d;
      scnt_q <= scnt_d;
      ptr_q  <= ptr_d;
      an_q   <= an_d;
      char_q <= char_d;
      if (wr_en) msg_q[wr_addr] <= wr_data;
    end
  end

  assign an   = an_q;
  assign char = char_q;
  assign ptr  = ptr_q;

endmodule

// File: tb/tb_led_scroll_driver.sv
// Randomized bench for led_scroll_driver against a count-based reference model.
module tb_led_scroll_driver;
  localparam int RD = 4;
  localparam int SD = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [3:0] an, char, ptr;

  led_scroll_driver #(.REFRESH_DIV(RD), .SCROLL_DIV(SD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .an(an), .char(char), .ptr(ptr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: t = cycles since reset, e = enabled cycles since reset.
  int mt, me;
  int mm [16];
  logic [3:0] exp_an, exp_char, exp_ptr;
`ifdef LED_SCROLL_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  function automatic void model_reset();
    mt = 0; me = 0;
    for (int i = 0; i < 16; i++) mm[i] = (i < 10) ? i : 13;
    exp_an = 4'hF; exp_char = 4'hD; exp_ptr = 4'h0;
  endfunction

  task automatic step();
    int phase, slot, p;
    @(posedge clk);
    if (!reset) model_reset();
    else begin
      phase = mt % RD;
      slot  = (mt / RD) % 4;
      p     = (me / SD) % 16;
      if (BLANK && (phase == 0 || phase == RD - 1)) exp_an = 4'hF;
      else exp_an = 4'(~(1 << (3 - slot)));
      if (phase == 0) exp_char = 4'(mm[(p + slot) % 16]);
      if (wr_en) mm[wr_addr] = wr_data;
      mt++;
      if (enable) me++;
      exp_ptr = 4'((me / SD) % 16);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; wr_en = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom); wr_data = 4'($urandom);
      step();
    end
    wr_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (an !== 4'hF || char !== 4'hD || ptr !== 4'h0) begin
      miscompares++;
      $display("FAIL async_reset an=%b char=%h ptr=%h want 1111/d/0", an, char, ptr);
    end
    step();
    reset = 1'b1;
    step();
    vectors++;
    if (char !== 4'h0 || an !== (BLANK ? 4'hF : 4'h7)) begin
      miscompares++;
      $display("FAIL first_capture char=%h an=%b", char, an);
    end
    for (int i = 0; i < 32; i++) begin
      step();
      vectors++;
      if (an !== exp_an || char !== exp_char || ptr !== exp_ptr) begin
        miscompares++;
        $display("FAIL reset_seq t=%0d an=%b/%b char=%h/%h ptr=%h/%h", mt, an, exp_an, char, exp_char, ptr, exp_ptr);
      end
    end
  endtask

  task automatic test_scroll_wrap();
    int steps_seen;
    logic [3:0] prev;
    do_reset();
    enable = 1'b1;
    steps_seen = 0; prev = ptr;
    for (int i = 0; i < 16 * SD; i++) begin
      step();
      if (ptr !== prev) steps_seen++;
      prev = ptr;
      vectors++;
      if (an !== exp_an || char !== exp_char || ptr !== exp_ptr) begin
        miscompares++;
        $display("FAIL scroll t=%0d an=%b/%b char=%h/%h ptr=%h/%h", mt, an, exp_an, char, exp_char, ptr, exp_ptr);
      end
    end
    vectors++;
    if (steps_seen != 16 || ptr !== 4'h0) begin
      miscompares++;
      $display("FAIL scroll_wrap steps=%0d ptr=%h want 16/0", steps_seen, ptr);
    end
  endtask

  task automatic test_enable_freeze();
    int n;
    logic [3:0] p0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      vectors++;
      if (ptr !== exp_ptr || an !== exp_an || char !== exp_char) begin
        miscompares++;
        $display("FAIL freeze t=%0d ptr=%h/%h an=%b/%b char=%h/%h", mt, ptr, exp_ptr, an, exp_an, char, exp_char);
      end
    end
    enable = 1'b1;
    p0 = ptr; n = 0;
    while (n < 200 && ptr === p0) begin
      step();
      n++;
    end
    vectors++;
    if (n != 34) begin
      miscompares++;
      $display("FAIL enable_freeze advance after %0d cycles want 34", n);
    end
  endtask

  task automatic test_mid_slot_write();
    do_reset();
    while (mt < 5) step();
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 4'd7;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (char !== 4'd1 || char !== exp_char) begin
        miscompares++;
        $display("FAIL mid_slot_hold char=%h want 1", char);
      end
      step();
    end
    while (mt < 21) begin
      step();
      vectors++;
      if (an !== exp_an || char !== exp_char) begin
        miscompares++;
        $display("FAIL mid_slot t=%0d an=%b/%b char=%h/%h", mt, an, exp_an, char, exp_char);
      end
    end
    vectors++;
    if (char !== 4'd7) begin
      miscompares++;
      $display("FAIL mid_slot_next_frame char=%h want 7", char);
    end
  endtask

  task automatic test_same_cycle_write();
    do_reset();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'hA;
    step();
    wr_en = 1'b0;
    vectors++;
    if (char !== 4'h0) begin
      miscompares++;
      $display("FAIL same_cycle_capture char=%h want 0", char);
    end
    while (mt < 17) step();
    vectors++;
    if (char !== 4'hA || char !== exp_char) begin
      miscompares++;
      $display("FAIL same_cycle_next_frame char=%h want a", char);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable  = 1'($urandom_range(0, 3) != 0);
      wr_en   = 1'($urandom_range(0, 3) == 0);
      wr_addr = 4'($urandom);
      wr_data = 4'($urandom);
      step();
      vectors++;
      if (an !== exp_an || char !== exp_char || ptr !== exp_ptr) begin
        miscompares++;
        $display("FAIL random t=%0d an=%b/%b char=%h/%h ptr=%h/%h", mt, an, exp_an, char, exp_char, ptr, exp_ptr);
      end
      if (!BLANK && an === 4'hF) begin
        miscompares++;
        $display("FAIL no_blank_anode t=%0d an=%b want one low", mt, an);
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scroll_wrap();
    test_enable_freeze();
    test_mid_slot_write();
    test_same_cycle_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
